pipe_if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage pipeline, directly upstream of the IF/ID pipeline register. It holds the program counter, drives the instruction-memory address, and selects the next PC from sequential, jump, jump-register, branch, exception and interrupt sources. It also produces the PC+4 value and the flush strobes that the IF/ID and ID/EX registers latch or obey. The PC follows the supervisor convention: PC[31]=1 is kernel mode.

---
 rtl/pipe_if_stage_if.sv | 37 +++
 rtl/pipe_if_stage.sv | 84 ++++++++
 tb/tb_pipe_if_stage.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_if_stage_if.sv
// Bundle of control, target and status signals between the fetch stage and
// the rest of the pipeline (hazard unit, ID, EX and the IF/ID/ID/EX registers).
// All signals are single-cycle, sampled at the rising clock edge; there is no
// valid/ready handshake: every input is a level that is acted on in the cycle
// it is present, and every output is valid every cycle.
interface pipe_if_stage_if;
    logic        PCWrite;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        JumpReg;
    logic [31:0] JumpRegTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic        Exception;
    logic [31:0] ExcEPC;
    logic        IRQ;
    logic [31:0] IMemAddr;
    logic [31:0] PCPlus4;
    logic        FlushIF;
    logic        FlushID;
    logic [31:0] EPC;
    logic        IRQPending;

    // Pipeline side: drives redirect requests, observes PC and flush strobes.
    modport master (
        output PCWrite, BranchTaken, BranchTarget, JumpReg, JumpRegTarget,
               Jump, JumpTarget, Exception, ExcEPC, IRQ,
        input  IMemAddr, PCPlus4, FlushIF, FlushID, EPC, IRQPending
    );

    // Fetch stage side.
    modport slave (
        input  PCWrite, BranchTaken, BranchTarget, JumpReg, JumpRegTarget,
               Jump, JumpTarget, Exception, ExcEPC, IRQ,
        output IMemAddr, PCPlus4, FlushIF, FlushID, EPC, IRQPending
    );
endinterface

// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection with fixed priority
// (exception, interrupt, branch, jump-register, jump, stall, sequential),
// exception return address capture and interrupt latching.
// PC[31] is the kernel-mode bit; sequential increment never alters it.
module pipe_if_stage #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] ILLOP_PC = 32'h8000_0004,
    parameter logic [31:0] XADR_PC  = 32'h8000_0008
) (
    input  logic           clk,
    input  logic           reset,
    pipe_if_stage_if.slave bus
);

    logic [31:0] pc;
    logic [31:0] epc;
    logic        irq_pending;

    logic        kernel;
    logic        irq_take;
    logic [31:0] pc_plus4;
    logic [31:0] jr_target;
    logic [31:0] jump_target;
    logic [31:0] pc_next;
    logic [31:0] epc_next;
    logic        irq_pending_next;

    // Next-PC selection, EPC capture and interrupt latch update.
    always_comb begin
        kernel      = pc[31];
        // Interrupts are only taken from user mode; kernel code runs with them masked.
        irq_take    = (irq_pending | bus.IRQ) & ~kernel;
        pc_plus4    = {pc[31], pc[30:0] + 31'd4};
        // User code cannot jump into kernel space; kernel code may return to user.
        jr_target   = kernel ? bus.JumpRegTarget : {1'b0, bus.JumpRegTarget[30:0]};
        jump_target = {pc[31], bus.JumpTarget[30:0]};

        pc_next          = pc_plus4;
        epc_next         = epc;
        irq_pending_next = irq_pending | bus.IRQ;

        if (bus.Exception) begin
            // The exception wins; a simultaneous interrupt stays latched for later.
            pc_next  = ILLOP_PC;
            epc_next = bus.ExcEPC;
        end else if (irq_take) begin
            pc_next          = XADR_PC;
            epc_next         = pc;
            irq_pending_next = 1'b0;
        end else if (bus.BranchTaken) begin
            pc_next = bus.BranchTarget;
        end else if (bus.JumpReg) begin
            pc_next = jr_target;
        end else if (bus.Jump) begin
            pc_next = jump_target;
        end else if (!bus.PCWrite) begin
            pc_next = pc;
        end
    end

    // PC, EPC and pending-interrupt registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            epc         <= 32'h0;
            irq_pending <= 1'b0;
        end else begin
            pc          <= pc_next;
            epc         <= epc_next;
            irq_pending <= irq_pending_next;
        end
    end

    // Outputs; flushes are combinational so they land in the redirect cycle.
    always_comb begin
        bus.IMemAddr   = pc;
        bus.PCPlus4    = pc_plus4;
        bus.EPC        = epc;
        bus.IRQPending = irq_pending;
        bus.FlushIF    = bus.Exception | irq_take | bus.BranchTaken | bus.JumpReg | bus.Jump;
        bus.FlushID    = bus.Exception | bus.BranchTaken;
    end

endmodule

// File: tb/tb_pipe_if_stage.sv
// Bench for pipe_if_stage: directed scenarios followed by random redirect
// traffic, checked by a scoreboard fed from a behavioural PC model.
module tb_pipe_if_stage;

    localparam int W = 99;  // {IMemAddr, PCPlus4, EPC, FlushIF, FlushID, IRQPending}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pipe_if_stage_if bus ();

    pipe_if_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic        m_pend;

    function automatic logic [31:0] seq_next(input logic [31:0] pc);
        // Add 4 within the low 31 bits, keep the mode bit untouched.
        return (pc & 32'h8000_0000) | ((pc + 32'd4) & 32'h7FFF_FFFF);
    endfunction

    task automatic model_reset();
        m_pc   = 32'h8000_0000;
        m_epc  = 32'h0;
        m_pend = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    // Drive one cycle's inputs, queue the expected outputs for this cycle,
    // then advance the model to the state after the coming clock edge.
    task automatic apply(input logic pcw, input logic br, input logic [31:0] bt,
                         input logic jr, input logic [31:0] jrt,
                         input logic j, input logic [31:0] jt,
                         input logic exc, input logic [31:0] exc_epc,
                         input logic irq);
        logic        user;
        logic        take;
        logic        fl_if;
        logic        fl_id;
        logic [31:0] nxt;
        bus.PCWrite       = pcw;
        bus.BranchTaken   = br;
        bus.BranchTarget  = bt;
        bus.JumpReg       = jr;
        bus.JumpRegTarget = jrt;
        bus.Jump          = j;
        bus.JumpTarget    = jt;
        bus.Exception     = exc;
        bus.ExcEPC        = exc_epc;
        bus.IRQ           = irq;

        user  = (m_pc < 32'h8000_0000);
        take  = (m_pend || irq) && user;
        fl_if = exc || take || br || jr || j;
        fl_id = exc || br;
        exp_q.push_back({m_pc, seq_next(m_pc), m_epc, fl_if, fl_id, m_pend});

        if (exc) begin
            nxt    = 32'h8000_0004;
            m_epc  = exc_epc;
            m_pend = m_pend || irq;
        end else if (take) begin
            nxt    = 32'h8000_0008;
            m_epc  = m_pc;
            m_pend = 1'b0;
        end else begin
            m_pend = m_pend || irq;
            if (br)       nxt = bt;
            else if (jr)  nxt = user ? (jrt % 32'h8000_0000) : jrt;
            else if (j)   nxt = (m_pc & 32'h8000_0000) | (jt & 32'h7FFF_FFFF);
            else if (!pcw) nxt = m_pc;
            else          nxt = seq_next(m_pc);
        end
        m_pc = nxt;
    endtask

    task automatic cycle(input logic pcw, input logic br, input logic [31:0] bt,
                         input logic jr, input logic [31:0] jrt,
                         input logic j, input logic [31:0] jt,
                         input logic exc, input logic [31:0] exc_epc,
                         input logic irq);
        @(posedge clk);
        #1;
        apply(pcw, br, bt, jr, jrt, j, jt, exc, exc_epc, irq);
        #1;
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic do_jr(input logic [31:0] t);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, t, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] act;
        logic [W-1:0] exp;
        if (!reset && exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            act = {bus.IMemAddr, bus.PCPlus4, bus.EPC, bus.FlushIF, bus.FlushID, bus.IRQPending};
            vectors++;
            if (act !== exp) begin
                miscompares++;
                $display("FAIL monitor: got pc=%08h p4=%08h epc=%08h fif=%b fid=%b pend=%b expected pc=%08h p4=%08h epc=%08h fif=%b fid=%b pend=%b at %0t",
                         act[98:67], act[66:35], act[34:3], act[2], act[1], act[0],
                         exp[98:67], exp[66:35], exp[34:3], exp[2], exp[1], exp[0], $time);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.PCWrite = 1'b0; bus.BranchTaken = 1'b0; bus.BranchTarget = '0;
        bus.JumpReg = 1'b0; bus.JumpRegTarget = '0; bus.Jump = 1'b0;
        bus.JumpTarget = '0; bus.Exception = 1'b0; bus.ExcEPC = '0; bus.IRQ = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state and free-running fetch
        apply(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        check("reset_pc", bus.IMemAddr, 32'h8000_0000);
        check("reset_pc4", bus.PCPlus4, 32'h8000_0004);
        check("reset_epc", bus.EPC, 32'h0);
        check("reset_flushif", {31'h0, bus.FlushIF}, 32'h0);
        idle(); check("seq1", bus.IMemAddr, 32'h8000_0004);
        idle(); check("seq2", bus.IMemAddr, 32'h8000_0008);
        idle(); check("seq3", bus.IMemAddr, 32'h8000_000C);

        // Stall, then branch during the stall
        do_jr(32'h0000_0010);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("stall0", bus.IMemAddr, 32'h0000_0010);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("stall1", bus.IMemAddr, 32'h0000_0010);
        cycle(1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("stall2", bus.IMemAddr, 32'h0000_0010);
        check("br_flushif", {31'h0, bus.FlushIF}, 32'h1);
        check("br_flushid", {31'h0, bus.FlushID}, 32'h1);
        idle(); check("br_target", bus.IMemAddr, 32'h0000_0100);

        // Interrupt from user mode, then latched interrupt in kernel mode
        do_jr(32'h0000_0020);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("irq_pc", bus.IMemAddr, 32'h0000_0020);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("irq_vec", bus.IMemAddr, 32'h8000_0008);
        check("irq_epc", bus.EPC, 32'h0000_0020);
        check("irq_pend0", {31'h0, bus.IRQPending}, 32'h0);
        do_jr(32'h0000_0024);
        check("kern_pend", {31'h0, bus.IRQPending}, 32'h1);
        check("kern_noredir", bus.IMemAddr, 32'h8000_000C);
        idle(); check("jr_user", bus.IMemAddr, 32'h0000_0024);
        check("late_take_flush", {31'h0, bus.FlushIF}, 32'h1);
        idle(); check("late_take_vec", bus.IMemAddr, 32'h8000_0008);
        check("late_take_pend", {31'h0, bus.IRQPending}, 32'h0);
        check("late_take_epc", bus.EPC, 32'h0000_0024);

        // User-mode jump-register masking and jump mode bit
        do_jr(32'h0000_0000);
        do_jr(32'h8000_0040);
        do_jr(32'h0000_0000);
        check("jr_mask", bus.IMemAddr, 32'h0000_0040);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h8FFF_FFF0, 1'b0, 32'h0, 1'b0);
        check("jump_from0", bus.IMemAddr, 32'h0000_0000);
        do_jr(32'h7FFF_FFFC);
        check("jump_mode", bus.IMemAddr, 32'h0FFF_FFF0);

        // Wrap at the top of user space, then exception with IRQ together
        idle(); check("pre_wrap", bus.IMemAddr, 32'h7FFF_FFFC);
        check("wrap_pc4", bus.PCPlus4, 32'h0000_0000);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0000_0030, 1'b1);
        check("wrap", bus.IMemAddr, 32'h0000_0000);
        check("exc_flushid", {31'h0, bus.FlushID}, 32'h1);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("exc_vec", bus.IMemAddr, 32'h8000_0004);
        check("exc_epc", bus.EPC, 32'h0000_0030);
        check("exc_pend", {31'h0, bus.IRQPending}, 32'h1);

        // Asynchronous reset in the middle of a cycle
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_pc", bus.IMemAddr, 32'h8000_0000);
        check("async_epc", bus.EPC, 32'h0);
        check("async_pend", {31'h0, bus.IRQPending}, 32'h0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        apply(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

        // Random redirect traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) == 0, $urandom,
                  $urandom_range(0, 7) == 0, $urandom,
                  $urandom_range(0, 7) == 0, $urandom,
                  $urandom_range(0, 19) == 0, $urandom,
                  $urandom_range(0, 9) == 0);
        end

        // Drain the scoreboard within a bounded number of cycles
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
